// File: rtl/nonogram_clue_loader_if.sv
// Byte-in / RAM-write-out bus of the nonogram clue loader.
// master = UART + option RAM side, slave = loader side.
interface nonogram_clue_loader_if #(
    parameter int ADDR_W = 10
);
    logic              axiiv;
    logic [7:0]        axiid;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [17:0]       dina;
    logic              axiov;

    modport master (output axiiv, axiid, input wea, addra, dina, axiov);
    modport slave  (input axiiv, axiid, output wea, addra, dina, axiov);
endinterface

// File: rtl/nonogram_clue_loader.sv
// Frames the UART byte stream into 18-bit header/option/end words for the option RAM.
// Latency: each write is registered, one cycle after the byte. Backpressure: none; bytes may arrive with any gap.
module nonogram_clue_loader #(
    parameter int         DEPTH      = 1024,
    parameter int         MAX_DIM    = 16,
    parameter logic [7:0] START_BYTE = 8'hA5,
    parameter logic [7:0] END_BYTE   = 8'h5A,
    localparam int        ADDR_W     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nonogram_clue_loader_if.slave  bus,
    output logic [ADDR_W:0]        num_words,
    output logic [4:0]             rows,
    output logic [4:0]             cols,
    output logic                   error,
    output logic                   busy
);
    typedef enum logic [2:0] {
        IDLE, ROWS, COLS, LCNT, OPT_HI, OPT_LO, ENDM, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        rows_w_q, rows_w_d, cols_w_q, cols_w_d;
    logic [5:0]        line_q, line_d;
    logic [7:0]        k_q, k_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [17:0]       dina_q, dina_d;
    logic              axiov_q, axiov_d;
    logic [ADDR_W:0]   num_words_q, num_words_d;
    logic [4:0]        rows_q, rows_d, cols_q, cols_d;
    logic              error_q, error_d, busy_q, busy_d;

    logic [15:0] opt_w;
    logic        last_line, is_col, opt_bad, at_limit, dim_bad;
    logic [5:0]  line_idx;

    assign opt_w     = {hi_q, bus.axiid};
    assign last_line = (line_q == ({1'b0, rows_w_q} + {1'b0, cols_w_q} - 6'd1));
    assign is_col    = (line_q >= {1'b0, rows_w_q});
    assign line_idx  = is_col ? (line_q - {1'b0, rows_w_q}) : line_q;
    // A row option may only use COLS bits, a column option only ROWS bits.
    assign opt_bad   = is_col ? ((opt_w >> rows_w_q) != 16'd0)
                              : ((opt_w >> cols_w_q) != 16'd0);
    // The last RAM word is kept free so the end word always fits.
    assign at_limit  = (wr_addr_q == ADDR_W'(DEPTH - 1));
    assign dim_bad   = (bus.axiid == 8'd0) || (bus.axiid > 8'(MAX_DIM));

    always_comb begin
        state_d     = state_q;
        rows_w_d    = rows_w_q;
        cols_w_d    = cols_w_q;
        line_d      = line_q;
        k_d         = k_q;
        hi_d        = hi_q;
        wr_addr_d   = wr_addr_q;
        wea_d       = 1'b0;
        addra_d     = addra_q;
        dina_d      = dina_q;
        axiov_d     = 1'b0;
        num_words_d = num_words_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        error_d     = error_q;
        busy_d      = busy_q;

        if (bus.axiiv) begin
            case (state_q)
                IDLE, ERR: begin
                    if (bus.axiid == START_BYTE) begin
                        state_d   = ROWS;
                        busy_d    = 1'b1;
                        error_d   = 1'b0;
                        wr_addr_d = '0;
                        addra_d   = '0;
                    end
                end
                ROWS: begin
                    rows_w_d = bus.axiid[4:0];
                    state_d  = dim_bad ? ERR : COLS;
                end
                COLS: begin
                    cols_w_d = bus.axiid[4:0];
                    line_d   = 6'd0;
                    state_d  = dim_bad ? ERR : LCNT;
                end
                LCNT: begin
                    if (at_limit) begin
                        state_d = ERR;
                    end else begin
                        wea_d     = 1'b1;
                        addra_d   = wr_addr_q;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        dina_d    = {2'b10, is_col, 1'b0, line_idx, bus.axiid};
                        k_d       = bus.axiid;
                        if (bus.axiid != 8'd0) begin
                            state_d = OPT_HI;
                        end else if (last_line) begin
                            state_d = ENDM;
                        end else begin
                            line_d = line_q + 6'd1;
                        end
                    end
                end
                OPT_HI: begin
                    hi_d    = bus.axiid;
                    state_d = OPT_LO;
                end
                OPT_LO: begin
                    if (opt_bad || at_limit) begin
                        state_d = ERR;
                    end else begin
                        wea_d     = 1'b1;
                        addra_d   = wr_addr_q;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        dina_d    = {2'b01, opt_w};
                        k_d       = k_q - 8'd1;
                        if (k_q != 8'd1) begin
                            state_d = OPT_HI;
                        end else if (last_line) begin
                            state_d = ENDM;
                        end else begin
                            line_d  = line_q + 6'd1;
                            state_d = LCNT;
                        end
                    end
                end
                ENDM: begin
                    if (bus.axiid == END_BYTE) begin
                        wea_d       = 1'b1;
                        addra_d     = wr_addr_q;
                        wr_addr_d   = wr_addr_q + ADDR_W'(1);
                        dina_d      = {2'b11, 3'b000, rows_w_q, 3'b000, cols_w_q};
                        axiov_d     = 1'b1;
                        num_words_d = {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, 1'b1};
                        rows_d      = rows_w_q;
                        cols_d      = cols_w_q;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: state_d = ERR;
            endcase
        end

        if ((state_d == ERR) && (state_q != ERR)) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_w_q    <= '0;
            cols_w_q    <= '0;
            line_q      <= '0;
            k_q         <= '0;
            hi_q        <= '0;
            wr_addr_q   <= '0;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            axiov_q     <= 1'b0;
            num_words_q <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_w_q    <= rows_w_d;
            cols_w_q    <= cols_w_d;
            line_q      <= line_d;
            k_q         <= k_d;
            hi_q        <= hi_d;
            wr_addr_q   <= wr_addr_d;
            wea_q       <= wea_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            axiov_q     <= axiov_d;
            num_words_q <= num_words_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.wea   = wea_q;
    assign bus.addra = addra_q;
    assign bus.dina  = dina_q;
    assign bus.axiov = axiov_q;
    assign num_words = num_words_q;
    assign rows      = rows_q;
    assign cols      = cols_q;
    assign error     = error_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_nonogram_clue_loader.sv
// Directed bench for nonogram_clue_loader: a DEPTH=1024 instance plus a DEPTH=8 instance for overflow.
module tb_nonogram_clue_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nonogram_clue_loader_if #(.ADDR_W(10)) bus_a ();
    nonogram_clue_loader_if #(.ADDR_W(3))  bus_b ();

    logic [10:0] nw_a;
    logic [4:0]  rows_a, cols_a;
    logic        err_a, busy_a;
    logic [3:0]  nw_b;
    logic [4:0]  rows_b, cols_b;
    logic        err_b, busy_b;

    nonogram_clue_loader #(.DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .num_words(nw_a),
        .rows(rows_a), .cols(cols_a), .error(err_a), .busy(busy_a)
    );
    nonogram_clue_loader #(.DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .num_words(nw_b),
        .rows(rows_b), .cols(cols_b), .error(err_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    int sel = 0;

    logic [9:0]  la_addr[$];
    logic [17:0] la_data[$];
    logic        la_ov[$];
    int          ov_cnt_a = 0;
    logic [2:0]  lb_addr[$];
    int          ov_cnt_b = 0;

    logic [7:0]  t1 [16] = '{8'hA5, 8'h02, 8'h02, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00,
                             8'h02, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h5A};
    logic [17:0] t1_exp [9] = '{18'h20001, 18'h10001, 18'h20101, 18'h10002, 18'h28000,
                                18'h28102, 18'h10001, 18'h10002, 18'h30202};
    logic [7:0]  t2 [10] = '{8'hA5, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h5A};
    logic [17:0] t2_exp [5] = '{18'h20001, 18'h10001, 18'h28001, 18'h10001, 18'h30101};

    always @(negedge clk) begin
        if (bus_a.wea) begin
            la_addr.push_back(bus_a.addra);
            la_data.push_back(bus_a.dina);
            la_ov.push_back(bus_a.axiov);
        end
        if (bus_a.axiov) ov_cnt_a = ov_cnt_a + 1;
        if (bus_b.wea) lb_addr.push_back(bus_b.addra);
        if (bus_b.axiov) ov_cnt_b = ov_cnt_b + 1;
    end

    task automatic clear_logs();
        la_addr.delete(); la_data.delete(); la_ov.delete(); lb_addr.delete();
        ov_cnt_a = 0; ov_cnt_b = 0;
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        if (sel == 0) begin bus_a.axiid = b; bus_a.axiiv = 1'b1; end
        else          begin bus_b.axiid = b; bus_b.axiiv = 1'b1; end
        @(negedge clk);
        bus_a.axiiv = 1'b0;
        bus_b.axiiv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_t1(input logic [7:0] last, input int maxgap);
        for (int i = 0; i < 15; i++) send_byte(t1[i], $urandom_range(0, maxgap));
        send_byte(last, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus_a.axiiv = 1'b0; bus_a.axiid = 8'h00;
        bus_b.axiiv = 1'b0; bus_b.axiid = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.wea, bus_a.addra, bus_a.dina, bus_a.axiov} !== 30'd0) begin
            errors++;
            $display("FAIL reset_bus: got wea=%b addra=%0d dina=%h axiov=%b, want all 0",
                     bus_a.wea, bus_a.addra, bus_a.dina, bus_a.axiov);
        end
        checks++;
        if ({nw_a, rows_a, cols_a, err_a, busy_a} !== 23'd0) begin
            errors++;
            $display("FAIL reset_status: got nw=%0d rows=%0d cols=%0d err=%b busy=%b, want all 0",
                     nw_a, rows_a, cols_a, err_a, busy_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_t1_frame();
        clear_logs();
        sel = 0;
        send_byte(8'h5A, 0);
        send_byte(8'h33, 1);
        send_t1(8'h5A, 0);
        checks++;
        if (la_addr.size() !== 9) begin
            errors++;
            $display("FAIL t1_count: got %0d writes, want 9", la_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (la_addr[i] !== 10'(i) || la_data[i] !== t1_exp[i]) begin
                    errors++;
                    $display("FAIL t1_word%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                             i, la_addr[i], la_data[i], i, t1_exp[i]);
                end
            end
            checks++;
            if (la_ov[8] !== 1'b1 || ov_cnt_a !== 1) begin
                errors++;
                $display("FAIL t1_axiov: got with_end=%b pulses=%0d, want 1 and 1", la_ov[8], ov_cnt_a);
            end
        end
        checks++;
        if (nw_a !== 11'd9 || err_a !== 1'b0 || busy_a !== 1'b0 || rows_a !== 5'd2 || cols_a !== 5'd2) begin
            errors++;
            $display("FAIL t1_status: got nw=%0d err=%b busy=%b rows=%0d cols=%0d, want 9 0 0 2 2",
                     nw_a, err_a, busy_a, rows_a, cols_a);
        end
    endtask

    task automatic test_bad_dim_then_restart();
        clear_logs();
        sel = 0;
        send_byte(8'hA5, 0);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL t2_busy: got busy=%b after start byte, want 1", busy_a);
        end
        send_byte(8'h00, 2);
        checks++;
        if (err_a !== 1'b1 || busy_a !== 1'b0 || la_addr.size() !== 0 || nw_a !== 11'd9) begin
            errors++;
            $display("FAIL t2_zero_rows: got err=%b busy=%b writes=%0d nw=%0d, want 1 0 0 9",
                     err_a, busy_a, la_addr.size(), nw_a);
        end
        for (int i = 0; i < 10; i++) send_byte(t2[i], 1);
        checks++;
        if (la_addr.size() !== 5) begin
            errors++;
            $display("FAIL t2_count: got %0d writes, want 5", la_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (la_addr[i] !== 10'(i) || la_data[i] !== t2_exp[i]) begin
                    errors++;
                    $display("FAIL t2_word%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                             i, la_addr[i], la_data[i], i, t2_exp[i]);
                end
            end
        end
        checks++;
        if (err_a !== 1'b0 || nw_a !== 11'd5 || ov_cnt_a !== 1 || rows_a !== 5'd1 || cols_a !== 5'd1) begin
            errors++;
            $display("FAIL t2_status: got err=%b nw=%0d pulses=%0d rows=%0d cols=%0d, want 0 5 1 1 1",
                     err_a, nw_a, ov_cnt_a, rows_a, cols_a);
        end
    endtask

    task automatic test_bad_option();
        clear_logs();
        sel = 0;
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h02, 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
        checks++;
        if (err_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL t3_error: got err=%b busy=%b right after bad option, want 1 0", err_a, busy_a);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (la_addr.size() !== 1 || la_data[0] !== 18'h20001 || nw_a !== 11'd5) begin
            errors++;
            $display("FAIL t3_writes: got writes=%0d first=%h nw=%0d, want 1 20001 5",
                     la_addr.size(), la_data[0], nw_a);
        end
    endtask

    task automatic test_bad_end();
        clear_logs();
        sel = 0;
        send_t1(8'h00, 0);
        checks++;
        if (la_addr.size() !== 8 || ov_cnt_a !== 0 || err_a !== 1'b1 || nw_a !== 11'd5) begin
            errors++;
            $display("FAIL t4_bad_end: got writes=%0d pulses=%0d err=%b nw=%0d, want 8 0 1 5",
                     la_addr.size(), ov_cnt_a, err_a, nw_a);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        sel = 1;
        send_t1(8'h5A, 0);
        checks++;
        if (lb_addr.size() !== 7 || err_b !== 1'b1 || ov_cnt_b !== 0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL t5_overflow: got writes=%0d err=%b pulses=%0d busy=%b, want 7 1 0 0",
                     lb_addr.size(), err_b, ov_cnt_b, busy_b);
        end
        for (int i = 0; i < lb_addr.size(); i++) begin
            checks++;
            if (lb_addr[i] !== 3'(i)) begin
                errors++;
                $display("FAIL t5_addr%0d: got %0d, want %0d", i, lb_addr[i], i);
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        sel = 0;
        send_byte(8'hA5, $urandom_range(0, 3)); send_byte(8'h02, $urandom_range(0, 3));
        send_byte(8'h02, $urandom_range(0, 3)); send_byte(8'h01, $urandom_range(0, 3));
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || bus_a.dina !== 18'd0 || nw_a !== 11'd0 || rows_a !== 5'd0) begin
            errors++;
            $display("FAIL t6_async_reset: got busy=%b dina=%h nw=%0d rows=%0d, want all 0",
                     busy_a, bus_a.dina, nw_a, rows_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        send_t1(8'h5A, 3);
        checks++;
        if (la_addr.size() !== 9) begin
            errors++;
            $display("FAIL t6_count: got %0d writes, want 9", la_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (la_addr[i] !== 10'(i) || la_data[i] !== t1_exp[i]) begin
                    errors++;
                    $display("FAIL t6_word%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                             i, la_addr[i], la_data[i], i, t1_exp[i]);
                end
            end
        end
        checks++;
        if (nw_a !== 11'd9 || ov_cnt_a !== 1 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL t6_status: got nw=%0d pulses=%0d err=%b, want 9 1 0", nw_a, ov_cnt_a, err_a);
        end
    endtask

    initial begin
        test_reset();
        test_t1_frame();
        test_bad_dim_then_restart();
        test_bad_option();
        test_bad_end();
        test_overflow();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
